// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and row/column decode helpers for the keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_e;

   localparam int         KEY_W     = 4;
   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   // True when exactly one line of an active-low group is asserted.
   function automatic logic one_low(input logic [3:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!v[i]) n = n + 3'd1;
      end
      return (n == 3'd1);
   endfunction

   // Position of the low bit; only meaningful when one_low() holds.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!v[i]) idx = i[1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler giving a one-cycle tick every SCAN_DIV clocks
module scan_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tick on the terminal count, then wrap back to zero.
   always_comb begin
      tick_o = (cnt_q == LAST);
      cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with debounce and single-pulse key report
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 8
) (
   input  logic             clk_M,
   input  logic             rst_n,
   input  logic [3:0]       row_in,
   output logic [3:0]       col_out,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_down
);

   localparam int            DW      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS);

   logic             tick;
   logic [3:0]       sync1_q, rows_s;
   state_e           state_q, state_d;
   logic [3:0]       col_q, col_d;
   logic [DW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [3:0]       cap_rows_q, cap_rows_d;
   logic [KEY_W-1:0] cap_code_q, cap_code_d;
   logic [KEY_W-1:0] key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_down_q, key_down_d;
   logic [3:0]       col_rot;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk_i  (clk_M),
      .rst_ni (rst_n),
      .tick_o (tick)
   );

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clk_M) begin
      if (!rst_n) begin
         sync1_q <= ROWS_IDLE;
         rows_s  <= ROWS_IDLE;
      end else begin
         sync1_q <= row_in;
         rows_s  <= sync1_q;
      end
   end

   assign col_rot = {col_q[2:0], col_q[3]};
   assign cnt_inc = cnt_q + DW'(1);

   // Scan/debounce FSM: acts only on tick cycles, otherwise everything holds.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      cnt_d       = cnt_q;
      cap_rows_d  = cap_rows_q;
      cap_code_d  = cap_code_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_down_d  = key_down_q;
      if (tick) begin
         case (state_q)
            SCAN: begin
               if (one_low(rows_s)) begin
                  cap_rows_d = rows_s;
                  cap_code_d = {low_index(rows_s), low_index(col_q)};
                  cnt_d      = DW'(1);
                  state_d    = DEBOUNCE;
               end else begin
                  col_d = col_rot;
               end
            end
            DEBOUNCE: begin
               if (rows_s == cap_rows_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_LAST) begin
                     state_d     = PRESSED;
                     key_code_d  = cap_code_q;
                     key_valid_d = 1'b1;
                     key_down_d  = 1'b1;
                  end
               end else begin
                  cnt_d   = '0;
                  col_d   = col_rot;
                  state_d = SCAN;
               end
            end
            PRESSED: begin
               // Counter is parked here, so it cannot overflow however long the key is held.
               if (rows_s == ROWS_IDLE) begin
                  cnt_d   = DW'(1);
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               if (rows_s == ROWS_IDLE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_LAST) begin
                     cnt_d      = '0;
                     key_down_d = 1'b0;
                     col_d      = col_rot;
                     state_d    = SCAN;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = PRESSED;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk_M) begin
      if (!rst_n) begin
         state_q     <= SCAN;
         col_q       <= COL_RESET;
         cnt_q       <= '0;
         cap_rows_q  <= ROWS_IDLE;
         cap_code_q  <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         cnt_q       <= cnt_d;
         cap_rows_q  <= cap_rows_d;
         cap_code_q  <= cap_code_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_down_q  <= key_down_d;
      end
   end

   assign col_out   = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_SCANS=3)
module tb_keypad_scan;

   logic       clk_M = 1'b0;
   logic       rst_n = 1'b0;
   wire  [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   logic       key_on    = 1'b0;
   logic       force_en  = 1'b0;
   logic [3:0] force_val = 4'b1111;

   int total  = 0;
   int bad    = 0;
   int cyc    = 0;
   int pulses = 0;

   // Keypad model: key at row 2, column 1 pulls row 2 low while column 1 is driven low.
   assign row_in = force_en ? force_val : ((key_on && !col_out[1]) ? 4'b1011 : 4'b1111);

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk_M     (clk_M),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down)
   );

   always #5 clk_M = ~clk_M;

   task automatic step();
      @(posedge clk_M);
      #1;
      cyc++;
      if (key_valid === 1'b1) pulses++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      cyc    = 0;
      pulses = 0;
   endtask

   task automatic test_reset();
      logic [3:0] seq [5];
      seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      key_on = 1'b0; force_en = 1'b0;
      do_reset();
      total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", col_out); end
      total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL reset_down got=%b exp=0", key_down); end
      for (int k = 1; k <= 4; k++) begin
         run_to(4 * k - 1);
         total++; if (col_out !== seq[k-1]) begin bad++; $display("FAIL scan_hold%0d got=%b exp=%b", k, col_out, seq[k-1]); end
         run_to(4 * k);
         total++; if (col_out !== seq[k]) begin bad++; $display("FAIL scan_step%0d got=%b exp=%b", k, col_out, seq[k]); end
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL scan_idle_pulses got=%0d exp=0", pulses); end
   endtask

   task automatic test_press();
      key_on = 1'b1; force_en = 1'b0;
      do_reset();
      run_to(15);
      total++; if (pulses !== 0) begin bad++; $display("FAIL press_early_pulses got=%0d exp=0", pulses); end
      total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL press_col_held got=%b exp=1101", col_out); end
      run_to(16);
      total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid got=%b exp=1", key_valid); end
      total++; if (key_code !== 4'd9) begin bad++; $display("FAIL press_code got=%0d exp=9", key_code); end
      total++; if (key_down !== 1'b1) begin bad++; $display("FAIL press_down got=%b exp=1", key_down); end
      total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL press_col got=%b exp=1101", col_out); end
      run_to(17);
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_valid_drop got=%b exp=0", key_valid); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_release_repress();
      pulses = 0;
      key_on = 1'b0;
      run_to(21);
      total++; if (key_down !== 1'b1) begin bad++; $display("FAIL rel_short_down got=%b exp=1", key_down); end
      key_on = 1'b1;
      run_to(25);
      key_on = 1'b0;
      run_to(35);
      total++; if (key_down !== 1'b1) begin bad++; $display("FAIL rel_before_done_down got=%b exp=1", key_down); end
      total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL rel_col_held got=%b exp=1101", col_out); end
      run_to(36);
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL rel_done_down got=%b exp=0", key_down); end
      total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL rel_resume_col got=%b exp=1011", col_out); end
      total++; if (key_code !== 4'd9) begin bad++; $display("FAIL rel_code_hold got=%0d exp=9", key_code); end
      total++; if (pulses !== 0) begin bad++; $display("FAIL rel_repress_pulses got=%0d exp=0", pulses); end
   endtask

   task automatic test_reset_mid();
      key_on = 1'b1;
      run_to(52);
      total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL mid_capture_col got=%b exp=1101", col_out); end
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL mid_capture_down got=%b exp=0", key_down); end
      run_to(53);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL mid_rst_col got=%b exp=1110", col_out); end
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL mid_rst_down got=%b exp=0", key_down); end
      total++; if (key_code !== 4'd0) begin bad++; $display("FAIL mid_rst_code got=%0d exp=0", key_code); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", key_valid); end
      cyc = 0; pulses = 0;
      run_to(15);
      total++; if (pulses !== 0) begin bad++; $display("FAIL mid_early_pulses got=%0d exp=0", pulses); end
      run_to(16);
      total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL mid_fresh_valid got=%b exp=1", key_valid); end
      total++; if (key_code !== 4'd9) begin bad++; $display("FAIL mid_fresh_code got=%0d exp=9", key_code); end
   endtask

   task automatic test_bounce();
      key_on = 1'b1; force_en = 1'b0;
      do_reset();
      run_to(9);
      key_on = 1'b0;
      run_to(11);
      total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL bounce_col_held got=%b exp=1101", col_out); end
      run_to(12);
      total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL bounce_resume_col got=%b exp=1011", col_out); end
      run_to(16);
      total++; if (col_out !== 4'b0111) begin bad++; $display("FAIL bounce_next_col got=%b exp=0111", col_out); end
      run_to(30);
      total++; if (pulses !== 0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL bounce_down got=%b exp=0", key_down); end
   endtask

   task automatic test_ghost();
      key_on = 1'b0; force_en = 1'b1; force_val = 4'b1001;
      do_reset();
      run_to(4);
      total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL ghost_first_col got=%b exp=1101", col_out); end
      run_to(40);
      total++; if (col_out !== 4'b1011) begin bad++; $display("FAIL ghost_col got=%b exp=1011", col_out); end
      total++; if (pulses !== 0) begin bad++; $display("FAIL ghost_pulses got=%0d exp=0", pulses); end
      total++; if (key_down !== 1'b0) begin bad++; $display("FAIL ghost_down got=%b exp=0", key_down); end
      force_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_press();
      test_release_repress();
      test_reset_mid();
      test_bounce();
      test_ghost();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Matrix-keypad scanner for a 4x4 keypad. It is the input-direction counterpart of the display digit-select refresh.
- Drives one keypad column low at a time at a divided scan rate and samples the row lines.
- Debounces, and reports a single debounced key press as a 4-bit code with a one-cycle valid strobe.
- Sits beside the display refresh logic on clk_M and feeds the car control/command logic.

Parameters:
- SCAN_DIV, 100000, clk_M cycles per scan tick (2 ms at 50 MHz). Legal range is at least 2.
- DEBOUNCE_SCANS, 8, consecutive identical scan-tick samples required to accept a press or a release. Legal range is 2..255.

Ports:
- clk_M  input  1  main clock, 50 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk_M.
- col_out  output  4  keypad column drive, one-hot-low.
- key_code  output  4  last accepted key, computed as row_index*4 + col_index.
- key_valid  output  1  one clk_M pulse when a press is accepted.
- key_down  output  1  high from press acceptance until release acceptance.

Behaviour:
- Clocking and reset: one clock, clk_M. rst_n is synchronous and active-low, sampled only on the clk_M rising edge.
- Reset values:
  - col_out = 4'b1110
  - key_code = 0, key_valid = 0, key_down = 0
  - state = SCAN
  - tick counter = 0, debounce counter = 0
  - synchronizer flops = 4'b1111
- Reset asserted mid-operation returns all of the above on the next edge; no pulse is emitted.
- Input sync: row_in passes through a 2-flop synchronizer to give rows_s. All decisions use rows_s only.
- Tick:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - tick is high for exactly one cycle when the count equals SCAN_DIV-1.
  - The FSM acts only on tick cycles and otherwise holds.
- Column rotation order: 1110 -> 1101 -> 1011 -> 0111 -> 1110. col_index is the position of the 0 bit.
- Row valid means exactly one bit of rows_s is 0. row_index is the position of that bit.
- Two or more bits low (ghosting or multi-key) is treated as no key.
- FSM:
  - SCAN, on tick:
    - If row valid: capture row_index, col_index and the rows_s pattern; set debounce cnt = 1; go to DEBOUNCE. The column is held.
    - Otherwise: rotate the column.
  - DEBOUNCE, on tick:
    - If rows_s equals the captured pattern: cnt++.
    - When cnt reaches DEBOUNCE_SCANS: go to PRESSED. On the next clk_M edge, set key_code = captured code, key_valid = 1 for that single cycle, key_down = 1.
    - If rows_s differs: cnt = 0, rotate the column, go to SCAN.
  - PRESSED, on tick:
    - If rows_s == 4'b1111: cnt = 1, go to RELEASE.
    - Otherwise stay. The column is held, and a change to another key is ignored until release.
  - RELEASE, on tick:
    - If rows_s == 4'b1111: cnt++. When cnt reaches DEBOUNCE_SCANS: key_down = 0, rotate the column, go to SCAN.
    - If any row is low: go to PRESSED with cnt = 0 and no new key_valid.
- Latency: key_valid rises 1 clk_M cycle after the tick on which cnt reaches DEBOUNCE_SCANS. That is DEBOUNCE_SCANS-1 ticks after the capture tick, plus the 2-cycle synchronizer delay on the input.
- key_code holds its value between presses. key_valid never stays high for more than one cycle.
- The counter width is sized from DEBOUNCE_SCANS. The counter must not overflow or wrap while the FSM sits in PRESSED.

Decomposition:
- Package keypad_pkg holds:
  - the state enum: SCAN, DEBOUNCE, PRESSED, RELEASE
  - COL_RESET = 4'b1110
  - KEY_W = 4
  - ROWS_IDLE = 4'b1111
- Sub-module scan_tick_gen: the SCAN_DIV prescaler that outputs the one-cycle tick. Share it with future refresh logic.
- The synchronizer is inline.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Reset with rows idle -> col_out cycles 1110,1101,1011,0111,1110 at 4-cycle spacing; key_valid stays 0.
2. Hold row_in=4'b1011 only while col_out=1101 (row2, col1), held for 3+ ticks -> exactly one key_valid pulse, key_code=9 (2*4+1), key_down=1, col_out frozen at 1101.
3. Press as in scenario 2, with row_in bouncing to 1111 on the second tick -> no key_valid, scanning resumes from 1011.
4. After scenario 2, release for 1 tick then press again -> no second key_valid. Then release for 3 ticks -> key_down=0, scanning resumes, key_code stays 9.
5. row_in=4'b1001 (two rows low) on any column -> no capture, no key_valid, scanning continues.
6. Assert rst_n=0 for 1 cycle during DEBOUNCE -> next cycle col_out=1110, key_down=0, key_code=0, and no key_valid afterwards without a fresh full debounce.
